sd_data_assembler: RTL

- Downstream consumer of the switch-selector/data sampler serial output DATA.
- Accumulates DATA bits sampled once per bit time (V1 strobe) into a 26-bit LVDC data word, MSB first.
- Presents the completed word to the processor-input path through a valid/ack handshake.
- Supports a single-bit discrete read mode selected by MBYPD.

---
 rtl/sd_pkg.sv | 17 +
 rtl/sd_shift_counter.sv | 44 ++++
 rtl/sd_data_assembler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the LVDC serial data assembler.
package sd_pkg;

  localparam int LVDC_WORD_BITS = 26;
  localparam int LVDC_SYL_BITS  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sd_state_e;

  function automatic logic odd_par(input logic [LVDC_SYL_BITS-1:0] syl);
    return ~^syl;
  endfunction

endpackage

// File: rtl/sd_shift_counter.sv
// MSB-first shift register with a saturating captured-bit counter.
module sd_shift_counter #(
  parameter int W     = 26,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [W-1:0]     shifted,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Value the register takes if din is captured this cycle; used for the word load.
  assign shifted = {sr_q[W-2:0], din};
  assign cnt     = cnt_q;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      sr_d = shifted;
      if (cnt_q != CNT_W'(W)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_data_assembler.sv
// Assembles V1-strobed serial DATA into a 26-bit LVDC word with valid/ack handoff.
// Optional syllable parity is built when SD_ASSEMBLER_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for START
// SHIFT | capturing DATA on each V1 strobe
// HOLD  | WORD complete and frozen until ACK
module sd_data_assembler
  import sd_pkg::*;
#(
  parameter int WORD_BITS = LVDC_WORD_BITS,
  parameter int SYL_BITS  = LVDC_SYL_BITS,
  parameter int CNT_W     = 5
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 V1,
  input  logic                 DATA,
  input  logic                 MBYPD,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 ACK,
  output logic [WORD_BITS-1:0] WORD,
  output logic                 WORD_VALID,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     BIT_CNT,
  output logic                 OVERRUN,
  output logic [1:0]           PAR
);

  localparam int LAST_IDX = 2 * SYL_BITS - 1;

  sd_state_e state_q, state_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic valid_q, valid_d;
  logic mode_q, mode_d;
  logic ovr_q, ovr_d;
  logic sc_clr, sc_en, load_word, load_byp;
  logic [WORD_BITS-1:0] shifted;
  logic [CNT_W-1:0] bit_cnt;

  sd_shift_counter #(.W(WORD_BITS), .CNT_W(CNT_W)) u_shift (
    .clk     (SIM_CLK),
    .rst_n   (SIM_RST),
    .clr     (sc_clr),
    .en      (sc_en),
    .din     (DATA),
    .shifted (shifted),
    .cnt     (bit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    mode_d    = mode_q;
    ovr_d     = ovr_q;
    sc_clr    = 1'b0;
    sc_en     = 1'b0;
    load_word = 1'b0;
    load_byp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d = SHIFT;
          sc_clr  = 1'b1;
          mode_d  = MBYPD;
        end
      end
      SHIFT: begin
        if (START) ovr_d = 1'b1;
        if (ABORT) begin
          state_d = IDLE;
          sc_clr  = 1'b1;
        end else if (V1) begin
          sc_en = 1'b1;
          if (mode_q) begin
            load_byp = 1'b1;
            state_d  = HOLD;
            valid_d  = 1'b1;
          end else if (bit_cnt == CNT_W'(LAST_IDX)) begin
            load_word = 1'b1;
            state_d   = HOLD;
            valid_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (ACK) begin
          valid_d = 1'b0;
          ovr_d   = 1'b0;
          if (START) begin
            state_d = SHIFT;
            sc_clr  = 1'b1;
            mode_d  = MBYPD;
          end else begin
            state_d = IDLE;
          end
        end else if (START) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    word_d = word_q;
    if (load_word)     word_d = shifted;
    else if (load_byp) word_d = WORD_BITS'(DATA);
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SD_ASSEMBLER_PARITY_EN
  logic [1:0] pacc_q, pacc_d, par_q, par_d;

  // First-received syllable accumulates into bit 1, second into bit 0.
  always_comb begin
    pacc_d = pacc_q;
    par_d  = par_q;
    if (sc_clr) begin
      pacc_d = '0;
    end else if (sc_en) begin
      if (bit_cnt < CNT_W'(SYL_BITS)) pacc_d[1] = pacc_q[1] ^ DATA;
      else                            pacc_d[0] = pacc_q[0] ^ DATA;
    end
    if (load_word)     par_d = {~pacc_q[1], ~(pacc_q[0] ^ DATA)};
    else if (load_byp) par_d = {odd_par('0), odd_par(LVDC_SYL_BITS'(DATA))};
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      pacc_q <= '0;
      par_q  <= '0;
    end else begin
      pacc_q <= pacc_d;
      par_q  <= par_d;
    end
  end

  assign PAR = par_q;
`else
  assign PAR = 2'b00;
`endif

  assign WORD       = word_q;
  assign WORD_VALID = valid_q;
  assign BUSY       = (state_q == SHIFT);
  assign BIT_CNT    = bit_cnt;
  assign OVERRUN    = ovr_q;

endmodule
